// File: rtl/pgs_pkg.sv
// -----------------------------------------------------------------------------
// pgs_pkg
// Shared types, constants and helpers for priority_grant_sequencer and its bench.
//   pgs_state_e   : sequencer FSM states (PGS_IDLE, PGS_SERVE)
//   PGS_N_DEF     : default request vector width
//   PGS_N_MAX     : widest vector onehot_to_idx can encode
//   onehot_to_idx : binary position of the set bit in a one-hot vector
// -----------------------------------------------------------------------------
package pgs_pkg;

    typedef enum logic [0:0] {
        PGS_IDLE  = 1'b0,
        PGS_SERVE = 1'b1
    } pgs_state_e;

    localparam int PGS_N_DEF = 16;
    localparam int PGS_N_MAX = 256;

    // ORing the indices of all set bits yields the position for a one-hot
    // input and 0 for an all-zero input, with no priority logic needed.
    function automatic logic [7:0] onehot_to_idx(input logic [PGS_N_MAX-1:0] onehot);
        logic [7:0] idx;
        idx = 8'd0;
        for (int i = 0; i < PGS_N_MAX; i++) begin
            if (onehot[i]) begin
                idx = idx | 8'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pgs_pick.sv
// -----------------------------------------------------------------------------
// pgs_pick
// Combinational one-hot priority picker over the pending request bits.
// Build option: PRIO_LSB_EN defined   -> lowest set bit wins.
//               PRIO_LSB_EN undefined -> highest set bit wins (default).
// Ports:
//   pending      in  [N-1:0]  bits still waiting for a grant
//   grant_onehot out [N-1:0]  the single winning bit, zero if pending is zero
// -----------------------------------------------------------------------------
module pgs_pick #(
    parameter int N = 16
) (
    input  logic [N-1:0] pending,
    output logic [N-1:0] grant_onehot
);

    logic [N-1:0] mask_s;

    // Thermometer mask: a bit stays enabled only while no higher-priority
    // pending bit has been seen on the way down the chain.
    always_comb begin
        mask_s = {N{1'b0}};
`ifdef PRIO_LSB_EN
        mask_s[0] = 1'b1;
        for (int i = 1; i < N; i++) begin
            mask_s[i] = ~pending[i-1] & mask_s[i-1];
        end
`else
        mask_s[N-1] = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            mask_s[i] = ~pending[i+1] & mask_s[i+1];
        end
`endif
        grant_onehot = pending & mask_s;
    end

endmodule

// File: rtl/priority_grant_sequencer.sv
// -----------------------------------------------------------------------------
// priority_grant_sequencer
// Latches a multi-hot request snapshot and hands out one grant per downstream
// handshake, in priority order, until the snapshot is drained.
// Build option: PRIO_LSB_EN selects lowest-bit-first order (see pgs_pick);
// default is highest-bit-first.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   req_valid    in   upstream offers req_vec
//   req_ready    out  a new vector can be accepted (IDLE)
//   req_vec      in   [N-1:0] request snapshot
//   grant_valid  out  a grant is presented
//   grant_ready  in   downstream consumes the current grant
//   grant_onehot out  [N-1:0] current grant, zero when no grant
//   grant_idx    out  [IDXW-1:0] binary position of grant, zero when no grant
//   busy         out  a vector is being served
//   done         out  one-cycle pulse after a vector drains or a zero vector
//                     is accepted
// -----------------------------------------------------------------------------
module priority_grant_sequencer
    import pgs_pkg::*;
#(
    parameter  int N    = PGS_N_DEF,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [N-1:0]    req_vec,
    output logic            grant_valid,
    input  logic            grant_ready,
    output logic [N-1:0]    grant_onehot,
    output logic [IDXW-1:0] grant_idx,
    output logic            busy,
    output logic            done
);

    pgs_state_e   state_r;
    logic [N-1:0] pending_r;
    logic         done_r;
    logic         req_ready_r;
    logic         busy_r;
    logic         grant_valid_r;
    logic [N-1:0] pick_s;
    logic [N-1:0] pending_next_s;

    pgs_pick #(
        .N (N)
    ) u_pick (
        .pending      (pending_r),
        .grant_onehot (pick_s)
    );

    // Pending bits left once the current grant has been consumed.
    always_comb begin
        pending_next_s = pending_r & ~pick_s;
    end

    // FSM, pending snapshot and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= PGS_IDLE;
            pending_r     <= {N{1'b0}};
            done_r        <= 1'b0;
            req_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            grant_valid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                PGS_IDLE: begin
                    if (req_valid) begin
                        if (req_vec != {N{1'b0}}) begin
                            pending_r     <= req_vec;
                            state_r       <= PGS_SERVE;
                            req_ready_r   <= 1'b0;
                            busy_r        <= 1'b1;
                            grant_valid_r <= 1'b1;
                        end else begin
                            // Nothing to grant: acknowledge with done only.
                            done_r <= 1'b1;
                        end
                    end
                end
                PGS_SERVE: begin
                    if (grant_ready) begin
                        pending_r <= pending_next_s;
                        if (pending_next_s == {N{1'b0}}) begin
                            state_r       <= PGS_IDLE;
                            done_r        <= 1'b1;
                            req_ready_r   <= 1'b1;
                            busy_r        <= 1'b0;
                            grant_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r       <= PGS_IDLE;
                    pending_r     <= {N{1'b0}};
                    req_ready_r   <= 1'b1;
                    busy_r        <= 1'b0;
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Grant outputs follow the pending register, forced to zero outside SERVE.
    always_comb begin
        if (grant_valid_r) begin
            grant_onehot = pick_s;
            grant_idx    = IDXW'(onehot_to_idx(PGS_N_MAX'(pick_s)));
        end else begin
            grant_onehot = {N{1'b0}};
            grant_idx    = {IDXW{1'b0}};
        end
    end

    assign req_ready   = req_ready_r;
    assign busy        = busy_r;
    assign grant_valid = grant_valid_r;
    assign done        = done_r;

endmodule

// File: tb/tb_priority_grant_sequencer.sv
// -----------------------------------------------------------------------------
// tb_priority_grant_sequencer
// Directed bench for priority_grant_sequencer (N=16). Expected drain orders
// follow the PRIO_LSB_EN build option.
// -----------------------------------------------------------------------------
module tb_priority_grant_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_vec;
    logic        grant_valid;
    logic        grant_ready;
    logic [15:0] grant_onehot;
    logic [3:0]  grant_idx;
    logic        busy;
    logic        done;

    int tests_run;
    int tests_failed;

    priority_grant_sequencer #(
        .N (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_vec      (req_vec),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a live grant at bit position idx.
    task automatic expect_grant(input string tag, input int idx);
        logic [15:0] oh;
        oh = 16'h0001 << idx;
        check({tag, ".valid"}, 32'(grant_valid), 32'h1);
        check({tag, ".onehot"}, 32'(grant_onehot), 32'(oh));
        check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
        check({tag, ".done"}, 32'(done), 32'h0);
    endtask

    // Expect the idle/reset output pattern with the given done value.
    task automatic expect_idle(input string tag, input logic exp_done);
        check({tag, ".req_ready"}, 32'(req_ready), 32'h1);
        check({tag, ".valid"}, 32'(grant_valid), 32'h0);
        check({tag, ".onehot"}, 32'(grant_onehot), 32'h0);
        check({tag, ".idx"}, 32'(grant_idx), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".done"}, 32'(done), 32'(exp_done));
    endtask

`ifdef PRIO_LSB_EN
    int ord_8421 [4] = '{0, 5, 10, 15};
    int ord_0003 [2] = '{0, 1};
    int ord_0011 [2] = '{0, 4};
`else
    int ord_8421 [4] = '{15, 10, 5, 0};
    int ord_0003 [2] = '{1, 0};
    int ord_0011 [2] = '{4, 0};
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_vec      = 16'h0000;
        grant_ready  = 1'b0;
        step();
        step();
        expect_idle("reset", 1'b0);
        rst_n = 1'b1;

        // Single-bit vector.
        req_valid   = 1'b1;
        req_vec     = 16'h0400;
        grant_ready = 1'b1;
        step();
        req_valid = 1'b0;
        expect_grant("single", 10);
        check("single.busy", 32'(busy), 32'h1);
        check("single.req_ready", 32'(req_ready), 32'h0);
        step();
        expect_idle("single_done", 1'b1);
        step();
        check("single.done_width", 32'(done), 32'h0);

        // Four-bit vector drained one per cycle.
        req_valid = 1'b1;
        req_vec   = 16'h8421;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_grant($sformatf("drain%0d", k), ord_8421[k]);
            step();
        end
        expect_idle("drain_done", 1'b1);
        step();
        check("drain.done_width", 32'(done), 32'h0);

        // Back-pressure: grant held while grant_ready low; req_vec changes ignored.
        req_valid   = 1'b1;
        req_vec     = 16'h0003;
        grant_ready = 1'b0;
        step();
        req_vec = 16'hF0F0;
        for (int k = 0; k < 3; k++) begin
            expect_grant($sformatf("stall%0d", k), ord_0003[0]);
            check($sformatf("stall%0d.busy", k), 32'(busy), 32'h1);
            step();
        end
        req_valid   = 1'b0;
        grant_ready = 1'b1;
        expect_grant("stall_rel0", ord_0003[0]);
        step();
        expect_grant("stall_rel1", ord_0003[1]);
        step();
        expect_idle("stall_done", 1'b1);
        step();

        // Zero vector: done only, no grant, never busy.
        req_valid = 1'b1;
        req_vec   = 16'h0000;
        step();
        req_valid = 1'b0;
        expect_idle("zero", 1'b1);
        step();
        expect_idle("zero_after", 1'b0);

        // Reset in the middle of serving a full vector.
        req_valid = 1'b1;
        req_vec   = 16'hFFFF;
        step();
        req_valid = 1'b0;
`ifdef PRIO_LSB_EN
        expect_grant("full0", 0);
`else
        expect_grant("full0", 15);
`endif
        for (int k = 0; k < 4; k++) begin
            step();
        end
`ifdef PRIO_LSB_EN
        expect_grant("full4", 4);
`else
        expect_grant("full4", 11);
`endif
        rst_n = 1'b0;
        step();
        expect_idle("midreset", 1'b0);
        rst_n = 1'b1;
        step();
        expect_idle("midreset_nodone", 1'b0);
        req_valid = 1'b1;
        req_vec   = 16'h0001;
        step();
        req_valid = 1'b0;
        expect_grant("post_reset", 0);
        step();
        expect_idle("post_reset_done", 1'b1);
        step();

        // Back-to-back vectors, second accepted in the done cycle.
        req_valid = 1'b1;
        req_vec   = 16'h0011;
        step();
        req_vec = 16'h0100;
        expect_grant("b2b0", ord_0011[0]);
        step();
        expect_grant("b2b1", ord_0011[1]);
        step();
        expect_idle("b2b_done1", 1'b1);
        step();
        req_valid = 1'b0;
        expect_grant("b2b2", 8);
        step();
        expect_idle("b2b_done2", 1'b1);
        step();
        expect_idle("b2b_end", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
